image_buffer_controller: RTL

Sequences a single still capture into the on-chip image buffer and arbitrates that buffer's single address port between the pixel writer and the SPI byte reader. Sits in the SPI clock domain between the already-synchronized crop output and the image buffer RAM. Replaces ad-hoc address muxing with an explicit capture FSM, write-priority arbitration and a read handshake.

---
 rtl/image_buffer_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/image_buffer_controller.sv
// Capture sequencer and write-priority arbiter for the single-port image buffer (SPI clock domain).
// Define IMAGE_BUFFER_CHECKSUM_EN to build the running 16-bit checksum of stored bytes.
module image_buffer_controller #(
    parameter int CAPTURE_SIZE = 40000,
    parameter int ADDR_W       = 16
) (
    input  logic              clock_spi_in,
    input  logic              reset_spi_in,
    input  logic              capture_request_in,
    input  logic              frame_valid_in,
    input  logic              pixel_valid_in,
    input  logic [7:0]        pixel_data_in,
    input  logic              read_request_in,
    output logic [7:0]        read_data_out,
    output logic              read_valid_out,
    output logic [ADDR_W-1:0] bytes_remaining_out,
    output logic              capture_busy_out,
    output logic              overflow_out,
    output logic [15:0]       checksum_out,
    output logic [ADDR_W-1:0] buffer_address_out,
    output logic [7:0]        buffer_write_data_out,
    output logic              buffer_write_enable_out,
    input  logic [7:0]        buffer_read_data_in
);
    // One extra bit so a full buffer of 2^ADDR_W bytes is still countable.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPTURE_SIZE);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURING, DONE} state_t;

    state_t           state;
    logic             fv_prev;
    logic [CNT_W-1:0] write_count;
    logic [CNT_W-1:0] read_pointer;
    logic [CNT_W-1:0] remaining;
    logic             rd_pend, rd_s1, rd_s2, rd_real1, rd_real2;
    logic             fv_rise, fv_fall, arm, pix, write_now, drop_now;
    logic             rd_busy, rd_want, rd_issue, rd_hit;

    assign fv_rise   = frame_valid_in & ~fv_prev;
    assign fv_fall   = ~frame_valid_in & fv_prev;
    assign arm       = ((state == IDLE) || (state == DONE)) && capture_request_in;
    assign pix       = (state == CAPTURING) && pixel_valid_in;
    assign write_now = pix && (write_count < CAP);
    assign drop_now  = pix && !(write_count < CAP);
    assign remaining = write_count - read_pointer;

    // A read is outstanding from acceptance until its data is returned.
    assign rd_busy  = rd_pend | rd_s1 | rd_s2;
    assign rd_want  = rd_pend | (read_request_in & ~rd_busy);
    assign rd_issue = rd_want & ~write_now;
    assign rd_hit   = (state == DONE) && (remaining != '0);

    assign bytes_remaining_out = (state == DONE) ? remaining[ADDR_W-1:0] : '0;

    always_ff @(posedge clock_spi_in or posedge reset_spi_in) begin
        if (reset_spi_in) begin
            state                   <= IDLE;
            fv_prev                 <= 1'b0;
            write_count             <= '0;
            read_pointer            <= '0;
            capture_busy_out        <= 1'b0;
            overflow_out            <= 1'b0;
            buffer_address_out      <= '0;
            buffer_write_data_out   <= '0;
            buffer_write_enable_out <= 1'b0;
            rd_pend                 <= 1'b0;
            rd_s1                   <= 1'b0;
            rd_s2                   <= 1'b0;
            rd_real1                <= 1'b0;
            rd_real2                <= 1'b0;
            read_valid_out          <= 1'b0;
            read_data_out           <= '0;
        end else begin
            fv_prev <= frame_valid_in;

            case (state)
                IDLE, DONE: if (arm) begin
                    state            <= ARMED;
                    capture_busy_out <= 1'b1;
                end
                ARMED: if (fv_rise) state <= CAPTURING;
                CAPTURING: if (fv_fall) begin
                    state            <= DONE;
                    capture_busy_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Port owner: write first; otherwise the address follows read_pointer.
            buffer_write_enable_out <= write_now;
            if (write_now) begin
                buffer_address_out    <= write_count[ADDR_W-1:0];
                buffer_write_data_out <= pixel_data_in;
                write_count           <= write_count + 1'b1;
            end else begin
                buffer_address_out <= read_pointer[ADDR_W-1:0];
            end
            if (drop_now) overflow_out <= 1'b1;

            rd_pend  <= rd_want & write_now;
            rd_s1    <= rd_issue;
            rd_real1 <= rd_issue & rd_hit;
            rd_s2    <= rd_s1;
            rd_real2 <= rd_real1;
            if (rd_issue && rd_hit) read_pointer <= read_pointer + 1'b1;

            read_valid_out <= rd_s2;
            if (rd_s2) read_data_out <= rd_real2 ? buffer_read_data_in : 8'h00;

            // Arming takes precedence over a read issued in the same cycle.
            if (arm) begin
                write_count  <= '0;
                read_pointer <= '0;
                overflow_out <= 1'b0;
            end
        end
    end

`ifdef IMAGE_BUFFER_CHECKSUM_EN
    logic [15:0] checksum;

    always_ff @(posedge clock_spi_in or posedge reset_spi_in) begin
        if (reset_spi_in)   checksum <= '0;
        else if (arm)       checksum <= '0;
        else if (write_now) checksum <= checksum + 16'(pixel_data_in);
    end

    assign checksum_out = checksum;
`else
    assign checksum_out = 16'h0000;
`endif

endmodule
